pipeline_hazard_ctrl: RTL and testbench

//   Pipeline control unit driving flush/freeze into the IF/ID and ID/EX stage registers.

---
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control unit: load-use/RAW stalls, branch flush, memory-wait freeze with timeout abort,
// plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_uses_src1,
  input  logic [3:0]       ex_dst,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [3:0]       mem_dst,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze_all,
  output logic             mem_abort,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ABORT} state_t;

  state_t            state_reg, state_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic              mem_error_reg, mem_error_set;
  logic [CNT_W-1:0]  stall_reg, flush_reg;
  logic              busy, match_ex, match_mem, hazard;

  assign busy      = mem_req & ~mem_ready;
  assign match_ex  = (id_uses_src1 & (id_src1 == ex_dst)) | (id_two_src & (id_src2 == ex_dst));
  assign match_mem = (id_uses_src1 & (id_src1 == mem_dst)) | (id_two_src & (id_src2 == mem_dst));
  // With forwarding only a load result still in EX cannot be bypassed in time.
  assign hazard    = forward_en ? (ex_mem_read & ex_wb_en & match_ex)
                                : ((ex_wb_en & match_ex) | (mem_wb_en & match_mem));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    mem_error_set = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (busy) begin
          state_next = ST_MEM_WAIT;
          timer_next = TMR_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_next = ST_RUN;
          timer_next = '0;
        end else if (timer_reg == TMR_W'(MEM_TIMEOUT)) begin
          state_next    = ST_ABORT;
          mem_error_set = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    freeze_if  = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    freeze_all = 1'b0;
    mem_abort  = 1'b0;
    case (state_reg)
      ST_RUN: begin
        freeze_all = busy;
        if (!busy) begin
          if (branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (hazard) begin
            freeze_if = 1'b1;
            flush_ex  = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        freeze_all = busy;
        if (!busy && branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      default: mem_abort = 1'b1;
    endcase
  end

  // Clear takes priority over both counting and a timeout flagged in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg     <= '0;
      flush_reg     <= '0;
      mem_error_reg <= 1'b0;
    end else if (cnt_clr) begin
      stall_reg     <= '0;
      flush_reg     <= '0;
      mem_error_reg <= 1'b0;
    end else begin
      if ((freeze_if | freeze_all) && (stall_reg != '1))
        stall_reg <= stall_reg + 1'b1;
      if (flush_id && (flush_reg != '1))
        flush_reg <= flush_reg + 1'b1;
      if (mem_error_set)
        mem_error_reg <= 1'b1;
    end
  end

  assign mem_error    = mem_error_reg;
  assign stall_cycles = stall_reg;
  assign flush_count  = flush_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench: a default-parameter instance and a small one (MEM_TIMEOUT=3,
// CNT_W=4) share inputs and are checked every cycle against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic forward_en, id_two_src, id_uses_src1, ex_wb_en, ex_mem_read, mem_wb_en;
  logic branch_taken, mem_req, mem_ready, cnt_clr;
  logic [3:0] id_src1, id_src2, ex_dst, mem_dst;

  logic fi_o[2], fid_o[2], fex_o[2], fa_o[2], ma_o[2], me_o[2];
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int total = 0;
  int bad = 0;

  // reference model state
  int  waited[2];
  bit  abort_p[2];
  bit  err[2];
  int  stall[2];
  int  flush[2];
  int  tmo[2]  = '{15, 3};
  int  cmax[2] = '{65535, 15};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .mem_dst(mem_dst), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .freeze_if(fi_o[0]), .flush_id(fid_o[0]), .flush_ex(fex_o[0]), .freeze_all(fa_o[0]),
    .mem_abort(ma_o[0]), .mem_error(me_o[0]), .stall_cycles(sc0), .flush_count(fc0)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(3), .TMR_W(8), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .mem_dst(mem_dst), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .freeze_if(fi_o[1]), .flush_id(fid_o[1]), .flush_ex(fex_o[1]), .freeze_all(fa_o[1]),
    .mem_abort(ma_o[1]), .mem_error(me_o[1]), .stall_cycles(sc1), .flush_count(fc1)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stall_obs(input int k);
    return (k == 0) ? int'(sc0) : int'(sc1);
  endfunction

  function automatic int flush_obs(input int k);
    return (k == 0) ? int'(fc0) : int'(fc1);
  endfunction

  function automatic bit reads(input logic [3:0] d);
    return (id_uses_src1 && id_src1 == d) || (id_two_src && id_src2 == d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      waited[k] = 0; abort_p[k] = 0; err[k] = 0; stall[k] = 0; flush[k] = 0;
    end
  endtask

  // Expected control outputs: abort cycle, else memory freeze, else branch, else hazard (only
  // when no memory wait is outstanding).
  task automatic model_out(input int k, output bit fi, output bit fid, output bit fex,
                           output bit fa, output bit ma);
    bit busy, haz;
    busy = mem_req && !mem_ready;
    fi = 0; fid = 0; fex = 0; fa = 0; ma = 0;
    if (abort_p[k]) ma = 1;
    else if (busy) fa = 1;
    else if (branch_taken) begin fid = 1; fex = 1; end
    else if (waited[k] == 0) begin
      if (forward_en) haz = ex_mem_read && ex_wb_en && reads(ex_dst);
      else haz = (ex_wb_en && reads(ex_dst)) || (mem_wb_en && reads(mem_dst));
      if (haz) begin fi = 1; fex = 1; end
    end
  endtask

  task automatic model_update(input int k, input bit fi, input bit fid, input bit fa);
    bit busy;
    busy = mem_req && !mem_ready;
    if (cnt_clr) begin
      stall[k] = 0; flush[k] = 0; err[k] = 0;
    end else begin
      if ((fi || fa) && stall[k] < cmax[k]) stall[k]++;
      if (fid && flush[k] < cmax[k]) flush[k]++;
    end
    if (abort_p[k]) begin
      abort_p[k] = 0; waited[k] = 0;
    end else if (waited[k] == 0) begin
      if (busy) waited[k] = 1;
    end else if (mem_ready) begin
      waited[k] = 0;
    end else if (waited[k] == tmo[k]) begin
      abort_p[k] = 1;
      if (!cnt_clr) err[k] = 1;
    end else begin
      waited[k]++;
    end
  endtask

  // Inputs are already applied; compare at the falling edge, then advance the model.
  task automatic step();
    bit fi, fid, fex, fa, ma;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_out(k, fi, fid, fex, fa, ma);
      check($sformatf("u%0d.freeze_if", k), int'(fi_o[k]), int'(fi));
      check($sformatf("u%0d.flush_id", k), int'(fid_o[k]), int'(fid));
      check($sformatf("u%0d.flush_ex", k), int'(fex_o[k]), int'(fex));
      check($sformatf("u%0d.freeze_all", k), int'(fa_o[k]), int'(fa));
      check($sformatf("u%0d.mem_abort", k), int'(ma_o[k]), int'(ma));
      check($sformatf("u%0d.mem_error", k), int'(me_o[k]), int'(err[k]));
      check($sformatf("u%0d.stall_cycles", k), stall_obs(k), stall[k]);
      check($sformatf("u%0d.flush_count", k), flush_obs(k), flush[k]);
      model_update(k, fi, fid, fa);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_uses_src1 = 0;
    ex_dst = 0; ex_wb_en = 0; ex_mem_read = 0; mem_dst = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    idle(); cnt_clr = 1; step(); cnt_clr = 0;
  endtask

  initial begin
    idle();
    rst = 0;
    model_reset();
    #2;
    check("reset.freeze_if", int'(fi_o[0]), 0);
    check("reset.flush_ex", int'(fex_o[0]), 0);
    check("reset.freeze_all", int'(fa_o[0]), 0);
    check("reset.mem_error", int'(me_o[0]), 0);
    check("reset.stall", int'(sc0), 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // load-use stall with forwarding
    clear_counters();
    forward_en = 1; ex_mem_read = 1; ex_wb_en = 1; ex_dst = 3; id_src1 = 3; id_uses_src1 = 1;
    #1;
    check("loaduse.freeze_if", int'(fi_o[0]), 1);
    check("loaduse.flush_ex", int'(fex_o[0]), 1);
    check("loaduse.flush_id", int'(fid_o[0]), 0);
    step();
    check("loaduse.stall", int'(sc0), 1);
    $display("txn loaduse stall=%0d", sc0);

    // branch overrides the hazard
    branch_taken = 1;
    #1;
    check("branch.flush_id", int'(fid_o[0]), 1);
    check("branch.freeze_if", int'(fi_o[0]), 0);
    step();
    check("branch.flush_count", int'(fc0), 1);
    $display("txn branch flush_count=%0d", fc0);

    // RAW on MEM-stage destination without forwarding, then with forwarding
    idle(); mem_wb_en = 1; mem_dst = 7; id_two_src = 1; id_src2 = 7;
    #1;
    check("raw.nofwd.freeze_if", int'(fi_o[0]), 1);
    step();
    forward_en = 1;
    #1;
    check("raw.fwd.freeze_if", int'(fi_o[0]), 0);
    check("raw.fwd.flush_ex", int'(fex_o[0]), 0);
    step();
    $display("txn raw forward_en toggle");

    // memory wait: 4 busy cycles then ready; branch during the wait is ignored
    clear_counters();
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("memwait.freeze_all", int'(fa_o[0]), 1);
      check("memwait.flush_id", int'(fid_o[0]), 0);
      step();
    end
    mem_ready = 1; branch_taken = 0;
    #1;
    check("memwait.done.freeze_all", int'(fa_o[0]), 0);
    step();
    check("memwait.stall", int'(sc0), 4);
    check("memwait.flush", int'(fc0), 0);
    $display("txn memwait stall=%0d", sc0);

    // timeout on the small instance
    idle(); step(); step();
    clear_counters();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("timeout.freeze_all", int'(fa_o[1]), 1);
      step();
    end
    #1;
    check("timeout.mem_abort", int'(ma_o[1]), 1);
    check("timeout.abort_freeze", int'(fa_o[1]), 0);
    check("timeout.mem_error", int'(me_o[1]), 1);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    check("timeout.sticky", int'(me_o[1]), 1);
    cnt_clr = 1; step(); cnt_clr = 0;
    check("timeout.cleared", int'(me_o[1]), 0);
    $display("txn timeout err_after_clr=%0d", me_o[1]);

    // stall saturation on the 4-bit counter
    idle(); for (int i = 0; i < 16; i++) step();
    clear_counters();
    ex_wb_en = 1; ex_dst = 1; id_src1 = 1; id_uses_src1 = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat.small", int'(sc1), 15);
    check("sat.large", int'(sc0), 20);
    $display("txn saturate small=%0d large=%0d", sc1, sc0);

    // asynchronous reset in the middle of a memory wait
    idle(); mem_req = 1; step(); step();
    idle(); rst = 0;
    #1;
    check("midrst.freeze_all", int'(fa_o[0]), 0);
    check("midrst.stall", int'(sc0), 0);
    check("midrst.mem_error", int'(me_o[1]), 0);
    model_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    step();
    $display("txn midreset stall=%0d", sc0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      forward_en   = 1'($urandom_range(0, 1));
      id_src1      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      id_uses_src1 = ($urandom_range(0, 3) != 0);
      ex_dst       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      ex_wb_en     = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      mem_dst      = 4'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 5) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 2) == 0);
      cnt_clr      = ($urandom_range(0, 39) == 0);
      step();
    end
    $display("txn random cycles=600 stall=%0d flush=%0d", sc0, fc0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
